// File: rtl/sort_check.sv
// Post-sort verification reader: streams the whole RAM through its second read
// port and reports ordering, descent count, first descent address and word sum.
module sort_check #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             start,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  output logic             busy,
  output logic             done,
  output logic             sorted,
  output logic [AW-1:0]    err_cnt,
  output logic [AW-1:0]    err_addr,
  output logic [DW+AW-1:0] sum
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   prev, prev_nxt;
  logic [AW-1:0]   rd_addr_nxt, err_cnt_nxt, err_addr_nxt;
  logic [DW+AW-1:0] sum_nxt;
  logic            busy_nxt, done_nxt, sorted_nxt;
  logic            is_desc;
  logic            last;

  // prev holds the word consumed on the previous edge; address 0 has no predecessor
  always_comb begin
    if (SIGNED != 0) is_desc = $signed(prev) > $signed(rd_data);
    else             is_desc = prev > rd_data;
  end

  assign last = (rd_addr == {AW{1'b1}});

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state    <= IDLE;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sorted   <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
      sum      <= '0;
      prev     <= '0;
    end else begin
      state    <= state_nxt;
      rd_addr  <= rd_addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      sorted   <= sorted_nxt;
      err_cnt  <= err_cnt_nxt;
      err_addr <= err_addr_nxt;
      sum      <= sum_nxt;
      prev     <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    sorted_nxt   = sorted;
    err_cnt_nxt  = err_cnt;
    err_addr_nxt = err_addr;
    sum_nxt      = sum;
    prev_nxt     = prev;
    case (state)
      IDLE: begin
        if (start) begin
          rd_addr_nxt  = '0;
          err_cnt_nxt  = '0;
          err_addr_nxt = '0;
          sum_nxt      = '0;
          sorted_nxt   = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = SCAN;
        end
      end
      SCAN: begin
        sum_nxt  = sum + {{AW{1'b0}}, rd_data};
        prev_nxt = rd_data;
        if (rd_addr != '0 && is_desc) begin
          err_cnt_nxt = err_cnt + AW'(1);
          if (err_cnt == '0) err_addr_nxt = rd_addr;
        end
        rd_addr_nxt = rd_addr + AW'(1);
        // the verdict must include a descent found on this final edge
        if (last) begin
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          sorted_nxt = (err_cnt_nxt == '0);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sort_check.sv
// Bench for sort_check: an unsigned and a signed instance read one shared RAM
// model; results are compared against a reference computed straight from the RAM.
module tb_sort_check;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        start;
  logic [15:0] ram [256];

  logic [7:0]  rd_addr_u, rd_addr_s, err_cnt_u, err_cnt_s, err_addr_u, err_addr_s;
  logic [15:0] rd_data_u, rd_data_s;
  logic        busy_u, busy_s, done_u, done_s, sorted_u, sorted_s;
  logic [23:0] sum_u, sum_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rd_data_u = ram[rd_addr_u];
  assign rd_data_s = ram[rd_addr_s];

  sort_check #(.AW(8), .DW(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst_p(rst_p), .start(start), .rd_addr(rd_addr_u), .rd_data(rd_data_u),
    .busy(busy_u), .done(done_u), .sorted(sorted_u), .err_cnt(err_cnt_u),
    .err_addr(err_addr_u), .sum(sum_u)
  );

  sort_check #(.AW(8), .DW(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst_p(rst_p), .start(start), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .busy(busy_s), .done(done_s), .sorted(sorted_s), .err_cnt(err_cnt_s),
    .err_addr(err_addr_s), .sum(sum_s)
  );

  // packed result view: {sorted, err_cnt, err_addr, sum}
  wire [40:0] res_u = {sorted_u, err_cnt_u, err_addr_u, sum_u};
  wire [40:0] res_s = {sorted_s, err_cnt_s, err_addr_s, sum_s};

  function automatic logic [40:0] expect_res(input bit sgn);
    int     cnt = 0;
    int     first = 0;
    longint total = 0;
    bit     gt;
    for (int i = 0; i < 256; i++) total += ram[i];
    for (int i = 1; i < 256; i++) begin
      if (sgn) gt = int'($signed(ram[i-1])) > int'($signed(ram[i]));
      else     gt = int'(ram[i-1]) > int'(ram[i]);
      if (gt) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    return {(cnt == 0), 8'(cnt), 8'(first), 24'(total)};
  endfunction

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts negedges after the start edge; done should show at n == 256
  task automatic wait_done(input int mid, output int n);
    n = 0;
    while (done_u !== 1'b1 && n < 600) begin
      start = (n == mid);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({res_u, busy_u, done_u, rd_addr_u} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_u: got %h busy=%b done=%b addr=%h, want all 0", res_u, busy_u, done_u, rd_addr_u);
    end
    checks++;
    if ({res_s, busy_s, done_s, rd_addr_s} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_s: got %h busy=%b done=%b addr=%h, want all 0", res_s, busy_s, done_s, rd_addr_s);
    end
    @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_u !== 1'b0 || done_u !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy_u, done_u);
    end
  endtask

  task automatic scan_and_check(input string name, input int mid);
    int n;
    logic [40:0] eu, es;
    eu = expect_res(1'b0);
    es = expect_res(1'b1);
    launch();
    checks++;
    if (busy_u !== 1'b1 || rd_addr_u !== 8'h00) begin
      errors++;
      $display("[TB] FAIL %s_launch: busy=%b addr=%h, want 1 00", name, busy_u, rd_addr_u);
    end
    wait_done(mid, n);
    checks++;
    if (n !== 256 || done_s !== 1'b1 || busy_u !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_latency: cycles=%0d done_s=%b busy=%b, want 256 1 0", name, n, done_s, busy_u);
    end
    checks++;
    if (res_u !== eu) begin
      errors++;
      $display("[TB] FAIL %s_unsigned: got %h want %h", name, res_u, eu);
    end
    checks++;
    if (res_s !== es) begin
      errors++;
      $display("[TB] FAIL %s_signed: got %h want %h", name, res_s, es);
    end
    @(negedge clk);
    checks++;
    if (done_u !== 1'b0 || busy_u !== 1'b0 || res_u !== eu) begin
      errors++;
      $display("[TB] FAIL %s_after: done=%b busy=%b res=%h, want 0 0 %h", name, done_u, busy_u, res_u, eu);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    scan_and_check("ramp", -1);
    checks++;
    if (sorted_u !== 1'b1 || err_cnt_u !== 8'd0 || err_addr_u !== 8'd0 || sum_u !== 24'h007F80) begin
      errors++;
      $display("[TB] FAIL ramp_const: got %h, want sorted=1 cnt=0 addr=0 sum=007F80", res_u);
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 256; i++) ram[i] = 16'hFFFF;
    scan_and_check("ones", -1);
    checks++;
    if (sorted_u !== 1'b1 || err_cnt_u !== 8'd0 || sum_u !== 24'hFFFF00) begin
      errors++;
      $display("[TB] FAIL ones_const: got %h, want sorted=1 cnt=0 sum=FFFF00", res_u);
    end
  endtask

  task automatic test_descending();
    for (int i = 0; i < 256; i++) ram[i] = 16'(255 - i);
    scan_and_check("desc", -1);
    checks++;
    if (sorted_u !== 1'b0 || err_cnt_u !== 8'd255 || err_addr_u !== 8'h01 || sum_u !== 24'h007F80) begin
      errors++;
      $display("[TB] FAIL desc_const: got %h, want sorted=0 cnt=255 addr=01 sum=007F80", res_u);
    end
  endtask

  task automatic test_mid_start();
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    ram[8'h80] = 16'h0081;
    ram[8'h81] = 16'h0080;
    scan_and_check("midstart", 100);
    checks++;
    if (err_cnt_u !== 8'd1 || err_addr_u !== 8'h81 || sorted_u !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midstart_const: cnt=%0d addr=%h sorted=%b, want 1 81 0", err_cnt_u, err_addr_u, sorted_u);
    end
  endtask

  task automatic test_signed();
    ram[0] = 16'hFFFF;
    for (int i = 1; i < 256; i++) ram[i] = 16'(i);
    scan_and_check("signed", -1);
    checks++;
    if (sorted_s !== 1'b1 || err_cnt_s !== 8'd0 || err_cnt_u !== 8'd1 || err_addr_u !== 8'h01) begin
      errors++;
      $display("[TB] FAIL signed_const: sorted_s=%b cnt_s=%0d cnt_u=%0d addr_u=%h, want 1 0 1 01",
               sorted_s, err_cnt_s, err_cnt_u, err_addr_u);
    end
  endtask

  task automatic fill_random(input int mode);
    int v;
    v = $urandom_range(0, 1000);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: ram[i] = 16'($urandom);
        1: begin v += $urandom_range(0, 200); ram[i] = 16'(v); end
        2: ram[i] = 16'($urandom_range(0, 3));
        3: ram[i] = 16'($urandom_range(16'h7FF0, 16'h800F));
        default: begin v += $urandom_range(0, 60); ram[i] = 16'(v + 16'h7000); end
      endcase
    end
    if (mode == 1) begin
      for (int k = 0; k < 3; k++) ram[$urandom_range(0, 255)] = 16'($urandom);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_random(r % 5);
      scan_and_check($sformatf("rand%0d", r), (r == 2) ? 17 : -1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [40:0] eu;
    fill_random(1);
    eu = expect_res(1'b0);
    launch();
    wait_done(-1, n);
    checks++;
    if (n !== 256 || res_u !== eu) begin
      errors++;
      $display("[TB] FAIL b2b_first: cycles=%0d res=%h, want 256 %h", n, res_u, eu);
    end
    fill_random(4);
    eu = expect_res(1'b0);
    launch();
    checks++;
    if (done_u !== 1'b0 || busy_u !== 1'b1 || rd_addr_u !== 8'h00) begin
      errors++;
      $display("[TB] FAIL b2b_restart: done=%b busy=%b addr=%h, want 0 1 00", done_u, busy_u, rd_addr_u);
    end
    wait_done(-1, n);
    checks++;
    if (n !== 256 || res_u !== eu) begin
      errors++;
      $display("[TB] FAIL b2b_second: cycles=%0d res=%h, want 256 %h", n, res_u, eu);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    fill_random(0);
    launch();
    repeat (100) @(negedge clk);
    #1 rst_p = 1'b1;
    #1;
    checks++;
    if ({res_u, busy_u, done_u, rd_addr_u} !== '0 || {res_s, busy_s, done_s, rd_addr_s} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: u=%h busy=%b done=%b s=%h, want all 0", res_u, busy_u, done_u, res_s);
    end
    repeat (3) @(negedge clk);
    rst_p = 1'b0;
    repeat (200) begin
      @(negedge clk);
      checks++;
      if (done_u !== 1'b0 || busy_u !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_nodone: done=%b busy=%b, want 0 0", done_u, busy_u);
      end
    end
    scan_and_check("postreset", -1);
  endtask

  initial begin
    rst_p = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_ramp();
    test_all_ones();
    test_descending();
    test_mid_start();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
